// File: rtl/cla_serial_addsub.sv
// cla_serial_addsub
//   Multi-cycle WIDTH-bit adder/subtractor. Each cycle in RUN resolves one
//   GROUP-bit carry-lookahead slice and registers the slice carry-out for
//   the next slice, so the critical path is one slice regardless of WIDTH.
//
// Ports
//   clk     rising-edge clock
//   rst     synchronous active-high reset
//   start   request, sampled only in IDLE or DONE
//   op_sub  0 = a+b, 1 = a-b (latched with start)
//   a, b    operands (latched with start)
//   busy    high while the operation is running
//   done    one-cycle pulse, result valid
//   s       registered sum/difference
//   co      carry out of the MSB (subtract: 1 = no borrow)
//   ovf     two's-complement overflow
module cla_serial_addsub #(
  parameter int WIDTH = 32,
  parameter int GROUP = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             op_sub,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] s,
  output logic             co,
  output logic             ovf
);

  localparam int N     = WIDTH / GROUP;
  localparam int IDX_W = (N > 1) ? $clog2(N) : 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  // Carries of one slice in flat sum-of-products form:
  // c[i+1] = OR over m of (gx[m] & p[m..i]), where gx[0] is the carry-in
  // and gx[m+1] = g[m]. No carry term depends on another computed carry.
  function automatic logic [GROUP:0] cla_carries(
    input logic [GROUP-1:0] g,
    input logic [GROUP-1:0] p,
    input logic             cin
  );
    logic [GROUP:0] gx;
    logic [GROUP:0] c;
    logic           term;
    gx = {g, cin};
    c  = '0;
    c[0] = cin;
    for (int i = 0; i < GROUP; i++) begin
      for (int m = 0; m <= i + 1; m++) begin
        term = gx[m];
        for (int k = m; k <= i; k++) begin
          term = term & p[k];
        end
        c[i+1] = c[i+1] | term;
      end
    end
    return c;
  endfunction

  state_t             state_r;
  state_t             state_next_s;
  logic [WIDTH-1:0]   a_r;
  logic [WIDTH-1:0]   b_r;
  logic [WIDTH-1:0]   w_r;
  logic               c_r;
  logic [IDX_W-1:0]   idx_r;
  logic               busy_r;
  logic               done_r;
  logic [WIDTH-1:0]   s_r;
  logic               co_r;
  logic               ovf_r;

  logic [GROUP-1:0]   g_s;
  logic [GROUP-1:0]   p_s;
  logic [GROUP:0]     carries_s;
  logic [GROUP-1:0]   sum_s;
  logic [WIDTH-1:0]   w_next_s;
  logic               last_s;
  logic               load_s;

  // Slice datapath: operands shift right one slice per RUN cycle, so the
  // active slice is always the low GROUP bits; results shift in at the top
  // of W and line up in place after the final slice.
  always_comb begin
    g_s       = a_r[GROUP-1:0] & b_r[GROUP-1:0];
    p_s       = a_r[GROUP-1:0] ^ b_r[GROUP-1:0];
    carries_s = cla_carries(g_s, p_s, c_r);
    sum_s     = p_s ^ carries_s[GROUP-1:0];
    w_next_s  = (w_r >> GROUP) | (WIDTH'(sum_s) << (WIDTH - GROUP));
    last_s    = (idx_r == IDX_W'(N - 1));
    load_s    = start && ((state_r == IDLE) || (state_r == DONE));
  end

  // Next-state logic of the IDLE/RUN/DONE controller.
  always_comb begin
    state_next_s = state_r;
    case (state_r)
      IDLE: begin
        if (start) state_next_s = RUN;
        else       state_next_s = IDLE;
      end
      RUN: begin
        if (last_s) state_next_s = DONE;
        else        state_next_s = RUN;
      end
      DONE: begin
        if (start) state_next_s = RUN;
        else       state_next_s = IDLE;
      end
      default: state_next_s = IDLE;
    endcase
  end

  // State, operand, working and output registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= IDLE;
      a_r     <= '0;
      b_r     <= '0;
      w_r     <= '0;
      c_r     <= 1'b0;
      idx_r   <= '0;
      busy_r  <= 1'b0;
      done_r  <= 1'b0;
      s_r     <= '0;
      co_r    <= 1'b0;
      ovf_r   <= 1'b0;
    end else begin
      state_r <= state_next_s;
      busy_r  <= (state_next_s == RUN);
      done_r  <= (state_next_s == DONE);
      if (load_s) begin
        a_r   <= a;
        b_r   <= op_sub ? ~b : b;
        c_r   <= op_sub;
        idx_r <= '0;
      end else if (state_r == RUN) begin
        a_r   <= a_r >> GROUP;
        b_r   <= b_r >> GROUP;
        w_r   <= w_next_s;
        c_r   <= carries_s[GROUP];
        idx_r <= idx_r + IDX_W'(1);
        if (last_s) begin
          s_r   <= w_next_s;
          co_r  <= carries_s[GROUP];
          // Overflow: carry into the MSB differs from carry out of it.
          ovf_r <= carries_s[GROUP] ^ carries_s[GROUP-1];
        end
      end
    end
  end

  assign busy = busy_r;
  assign done = done_r;
  assign s    = s_r;
  assign co   = co_r;
  assign ovf  = ovf_r;

endmodule

// File: tb/tb_cla_serial_addsub.sv
module tb_cla_serial_addsub;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic        op_sub = 1'b0;
  logic [31:0] a = 32'd0;
  logic [31:0] b = 32'd0;

  logic        m_busy, m_done, m_co, m_ovf;
  logic [31:0] m_s;
  logic        x_busy, x_done, x_co, x_ovf;
  logic [7:0]  x_s;
  logic        y_busy, y_done, y_co, y_ovf;
  logic [15:0] y_s;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  cla_serial_addsub #(.WIDTH(32), .GROUP(4)) u_main (
    .clk(clk), .rst(rst), .start(start), .op_sub(op_sub), .a(a), .b(b),
    .busy(m_busy), .done(m_done), .s(m_s), .co(m_co), .ovf(m_ovf)
  );

  cla_serial_addsub #(.WIDTH(8), .GROUP(8)) u_w8 (
    .clk(clk), .rst(rst), .start(start), .op_sub(op_sub), .a(a[7:0]), .b(b[7:0]),
    .busy(x_busy), .done(x_done), .s(x_s), .co(x_co), .ovf(x_ovf)
  );

  cla_serial_addsub #(.WIDTH(16), .GROUP(4)) u_w16 (
    .clk(clk), .rst(rst), .start(start), .op_sub(op_sub), .a(a[15:0]), .b(b[15:0]),
    .busy(y_busy), .done(y_done), .s(y_s), .co(y_co), .ovf(y_ovf)
  );

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Reference: plain modular arithmetic plus the sign rule for overflow.
  function automatic logic [33:0] ref_model(input int w, input logic [31:0] x,
                                             input logic [31:0] y, input logic sub);
    logic [63:0] mask, xa, yb, full, res;
    logic        cout, sa, sb, sr, ov;
    mask = (64'd1 << w) - 64'd1;
    xa   = {32'd0, x} & mask;
    yb   = {32'd0, y} & mask;
    if (sub) full = xa + ((~yb) & mask) + 64'd1;
    else     full = xa + yb;
    cout = full[w];
    res  = full & mask;
    sa   = xa[w-1];
    sb   = yb[w-1];
    sr   = res[w-1];
    if (sub) ov = (sa != sb) && (sr != sa);
    else     ov = (sa == sb) && (sr != sa);
    return {ov, cout, res[31:0]};
  endfunction

  // One operation on the 32-bit instance with full cycle-accurate checks.
  task automatic main_op(input string tag, input logic [31:0] xa, input logic [31:0] xb,
                         input logic xsub, input int pulse_at, input logic [31:0] exp_s,
                         input logic exp_co, input logic exp_ovf);
    int cyc, busy_cnt, both_cnt;
    bit seen;
    @(negedge clk);
    start = 1'b1; a = xa; b = xb; op_sub = xsub;
    @(negedge clk);
    start = 1'b0;
    cyc = 1; busy_cnt = 0; both_cnt = 0; seen = 0;
    while (!seen && cyc < 40) begin
      if (m_busy && m_done) both_cnt++;
      if (m_done) seen = 1;
      else begin
        if (m_busy) busy_cnt++;
        if (cyc == pulse_at) begin
          start = 1'b1; a = 32'hDEADBEEF; b = 32'h0BADF00D; op_sub = 1'b1;
        end else begin
          start = 1'b0;
        end
        @(negedge clk);
        cyc++;
      end
    end
    check_eq({tag, "_done_seen"}, 64'(seen), 64'd1);
    check_eq({tag, "_latency"}, 64'(cyc), 64'd9);
    check_eq({tag, "_busy_cycles"}, 64'(busy_cnt), 64'd8);
    check_eq({tag, "_busy_done_excl"}, 64'(both_cnt), 64'd0);
    check_eq({tag, "_s"}, 64'(m_s), 64'(exp_s));
    check_eq({tag, "_co"}, 64'(m_co), 64'(exp_co));
    check_eq({tag, "_ovf"}, 64'(m_ovf), 64'(exp_ovf));
    @(negedge clk);
    check_eq({tag, "_done_pulse"}, 64'(m_done), 64'd0);
  endtask

  // One random vector applied to all three instances at once.
  task automatic rand_vec();
    logic [31:0] ra, rb;
    logic        rs;
    int          dm, dx, dy;
    ra = $urandom;
    rb = $urandom;
    rs = 1'($urandom_range(0, 1));
    if ($urandom_range(0, 7) == 0) rb = rs ? ra : ~ra;
    dm = -1; dx = -1; dy = -1;
    @(negedge clk);
    start = 1'b1; a = ra; b = rb; op_sub = rs;
    @(negedge clk);
    start = 1'b0;
    for (int c = 1; c <= 10; c++) begin
      if (x_done && dx < 0) begin
        dx = c;
        check_eq("w8_result", 64'({x_ovf, x_co, 24'd0, x_s}), 64'(ref_model(8, ra, rb, rs)));
      end
      if (y_done && dy < 0) begin
        dy = c;
        check_eq("w16_result", 64'({y_ovf, y_co, 16'd0, y_s}), 64'(ref_model(16, ra, rb, rs)));
      end
      if (m_done && dm < 0) begin
        dm = c;
        check_eq("w32_result", 64'({m_ovf, m_co, m_s}), 64'(ref_model(32, ra, rb, rs)));
      end
      @(negedge clk);
    end
    check_eq("w8_latency", 64'(dx), 64'd2);
    check_eq("w16_latency", 64'(dy), 64'd5);
    check_eq("w32_latency", 64'(dm), 64'd9);
  endtask

  initial begin
    int t1, t2, cyc, dcount;
    bit seen;

    // Reset held for two cycles.
    repeat (2) @(negedge clk);
    rst = 1'b0;
    check_eq("reset_busy", 64'(m_busy), 64'd0);
    check_eq("reset_done", 64'(m_done), 64'd0);
    check_eq("reset_s", 64'(m_s), 64'd0);
    check_eq("reset_co", 64'(m_co), 64'd0);
    check_eq("reset_ovf", 64'(m_ovf), 64'd0);

    main_op("carry_chain", 32'hFFFFFFFF, 32'h00000001, 1'b0, 0, 32'h00000000, 1'b1, 1'b0);
    main_op("add_ovf", 32'h7FFFFFFF, 32'h00000001, 1'b0, 0, 32'h80000000, 1'b0, 1'b1);
    repeat (3) @(negedge clk);
    check_eq("hold_s_idle", 64'(m_s), 64'h80000000);
    main_op("sub_ovf", 32'h80000000, 32'h00000001, 1'b1, 0, 32'h7FFFFFFF, 1'b1, 1'b1);
    main_op("sub_neg", 32'h00000005, 32'h00000007, 1'b1, 0, 32'hFFFFFFFE, 1'b0, 1'b0);
    main_op("start_in_run", 32'h12345678, 32'h11111111, 1'b0, 3, 32'h23456789, 1'b0, 1'b0);

    // Back-to-back: start held high through DONE.
    @(negedge clk);
    start = 1'b1; a = 32'd1; b = 32'd2; op_sub = 1'b0;
    cyc = 0; seen = 0; t1 = -1; t2 = -1;
    while (!seen && cyc < 40) begin
      @(negedge clk);
      cyc++;
      if (m_done) begin seen = 1; t1 = cyc; end
      else seen = 0;
    end
    check_eq("b2b_first_s", 64'(m_s), 64'd3);
    a = 32'd10; b = 32'd20;
    @(negedge clk);
    cyc++;
    check_eq("b2b_no_idle", 64'(m_busy), 64'd1);
    start = 1'b0;
    seen = 0;
    while (!seen && cyc < 80) begin
      @(negedge clk);
      cyc++;
      if (m_done) begin seen = 1; t2 = cyc; end
      else seen = 0;
    end
    check_eq("b2b_spacing", 64'(t2 - t1), 64'd9);
    check_eq("b2b_second_s", 64'(m_s), 64'd30);
    @(negedge clk);

    // Reset in the middle of an add.
    start = 1'b1; a = 32'hAAAA0000; b = 32'h00005555; op_sub = 1'b0;
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check_eq("midrst_busy", 64'(m_busy), 64'd0);
    check_eq("midrst_done", 64'(m_done), 64'd0);
    check_eq("midrst_outs", 64'({m_ovf, m_co, m_s}), 64'd0);
    dcount = 0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (m_done) dcount++;
    end
    check_eq("midrst_no_done", 64'(dcount), 64'd0);
    main_op("after_rst", 32'd3, 32'd4, 1'b0, 0, 32'd7, 1'b0, 1'b0);

    for (int v = 0; v < 1000; v++) rand_vec();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/cla_serial_addsub.md
# cla_serial_addsub

Parametrised, multi-cycle WIDTH-bit adder/subtractor. It processes one GROUP-bit carry-lookahead slice per clock and ripples a registered carry between slices. It is the next generation of the team's 4-bit CLA datapath: arbitrary width, a subtract mode, signed-overflow detection and a start/done handshake. It sits in the datapath wherever a wide add is needed and its latency can be traded for area.

## Interface
- WIDTH, default 32: operand/result width. Must be a multiple of GROUP.
- GROUP, default 4: bits per lookahead slice. N = WIDTH/GROUP cycles per operation. GROUP = WIDTH (N = 1) is legal.

- clk  input  1  rising-edge clock. This is the only clock.
- rst  input  1  reset, synchronous and active-high.
- start  input  1  request. Sampled only in IDLE or DONE.
- op_sub  input  1  0 = a+b, 1 = a−b. Latched with start.
- a  input  WIDTH  operand A. Latched with start.
- b  input  WIDTH  operand B. Latched with start.
- busy  output  1  high while in RUN.
- done  output  1  one-cycle pulse; result valid.
- s  output  WIDTH  sum/difference, registered.
- co  output  1  carry out of the MSB (for subtraction, 1 means no borrow).
- ovf  output  1  two's-complement overflow.

## Operation
- States: IDLE, RUN, DONE.
- IDLE: start=1 → RUN. Latch A←a and B←(op_sub ? ~b : b). Set carry register c←op_sub and idx←0. start=0 → stay in IDLE.
- RUN: each cycle, slice idx (bits idx·GROUP … idx·GROUP+GROUP−1) is computed as follows:
  - g_i = A_i & B_i and p_i = A_i ^ B_i.
  - Lookahead carries: c_{i+1} = g_i | p_i & c_i, expanded in flat AND/OR form with no in-slice ripple.
  - sum_i = p_i ^ c_i.
  - Write the slice sum into the working register W.
  - Update c ← carry out of the slice, and idx ← idx+1.
- RUN, when idx = N−1: after computing that slice, load the outputs and go to DONE.
  - s ← W with the final slice merged in.
  - co ← carry out of the slice.
  - ovf ← (carry into bit WIDTH−1) ^ (carry out of bit WIDTH−1).
- DONE: done=1 for this cycle only.
  - start=1 → RUN with new operands (back-to-back). Otherwise → IDLE.
- start in RUN is ignored. Operands do not change and no error is flagged.
- s, co and ovf change only on the transition into DONE. They hold their value through IDLE and through any subsequent RUN until the next completion.
- rst=1 at any edge, including mid-RUN: state←IDLE, idx←0, c←0, W←0, s←0, co←0, ovf←0. done and busy are low in the cycle after. The operation in flight is discarded and produces no done.
- rst has priority over start in the same cycle.
- Result is exact modulo 2^WIDTH. Subtraction is A + ~B + 1.

## Timing
- Reset values: busy=0, done=0, s=0, co=0, ovf=0.
- Start accepted at edge k, then:
  - busy=1 in cycles k+1 … k+N.
  - Result is loaded at edge k+N.
  - done=1 in the cycle after edge k+N.
  - Latency is N+1 cycles from the start edge to done.
- Throughput is one operation every N+1 cycles when start is held high (restart from DONE).
- busy and done are never high together. done never lasts more than one cycle.
- N=1: RUN lasts one cycle, then DONE.
- Critical path is one GROUP-bit lookahead slice plus carry-register setup. It is independent of WIDTH.

## Test plan
All scenarios use WIDTH=32 and GROUP=4 (N=8) unless noted.
- Reset: hold rst 2 cycles → busy=0, done=0, s=0, co=0, ovf=0.
- Full carry chain: a=0xFFFFFFFF, b=1, op_sub=0, start at edge k →
  - busy high for cycles k+1…k+8.
  - done in the cycle after edge k+8.
  - s=0x00000000, co=1, ovf=0.
- Signed overflow:
  - Add 0x7FFFFFFF+1 → s=0x80000000, co=0, ovf=1.
  - Subtract 0x80000000−1 → s=0x7FFFFFFF, co=1, ovf=1.
  - Subtract 5−7 → s=0xFFFFFFFE, co=0, ovf=0.
- Handshake:
  - start pulsed mid-RUN with different operands → ignored; the first result (0x12345678+0x11111111=0x23456789) completes on schedule.
  - start held high through DONE → second operation begins with no IDLE cycle; its done arrives 9 cycles after the first.
- Reset mid-operation: rst asserted at cycle k+4 of an add, then released → no done, all outputs 0. A fresh 3+4 yields s=7 with normal latency.
- Parameter corners: random add/subtract against a reference model (≥1000 vectors) for WIDTH=8/GROUP=8 (N=1, done 2 cycles after start) and WIDTH=16/GROUP=4.
